// File: rtl/ifu_pkg.sv
// Shared fetch-unit types: FSM state encoding and redirect-source selects.
package ifu_state_enum;

  typedef enum logic [1:0] {
    IFU_IDLE,
    IFU_REQ,
    IFU_VALID,
    IFU_HALT
  } ifu_state_t;

  localparam logic PC_WR_IMM = 1'b0;
  localparam logic PC_WR_ALU = 1'b1;

endpackage

// File: rtl/ifu_pcgen.sv
// Next-PC generator: sequential, PC-relative or register-indirect target plus alignment check.
module pcgen
  import ifu_state_enum::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic            pc_wr_en,
  input  logic            pc_wr_sel,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic signed [XLEN-1:0] pc_s;
  logic signed [XLEN-1:0] imm_s;

  assign pc_s  = $signed(pc);
  assign imm_s = $signed(imm);

  always_comb begin
    target = pc + XLEN'(4);
    if (pc_wr_en) begin
      if (pc_wr_sel == PC_WR_ALU) begin
        target = {alu[XLEN-1:1], 1'b0};
      end else begin
        target = $unsigned(pc_s + imm_s);
      end
    end
  end

  // Bit 0 is either cleared (JALR) or carried from pc+imm; only bit 1 marks a bad word target.
  assign misaligned = target[1];

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC, fetches one word at a time and holds it for decode.
module ifu
  import ifu_state_enum::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            pc_wr_en_i,
  input  logic            pc_wr_sel_i,
  input  logic [XLEN-1:0] imm_data_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic            inst_ready_i,
  output logic            iram_rd_en_o,
  output logic [XLEN-1:0] iram_rd_addr_o,
  input  logic            iram_rd_valid_i,
  input  logic [XLEN-1:0] iram_rd_data_i,
  output logic            inst_valid_o,
  output logic [XLEN-1:0] inst_data_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_next_o,
  output logic            misalign_o
);

  ifu_state_t      state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] inst_data_q;
  logic            inst_valid_q;
  logic            misalign_q;
  logic [XLEN-1:0] target;
  logic            target_misaligned;
  logic            accept_data;
  logic            retire;

  pcgen #(.XLEN(XLEN)) u_pcgen (
    .pc         (pc_q),
    .pc_wr_en   (pc_wr_en_i),
    .pc_wr_sel  (pc_wr_sel_i),
    .imm        (imm_data_i),
    .alu        (alu_data_i),
    .target     (target),
    .misaligned (target_misaligned)
  );

  // Handshakes only count in their own state; anything else is spurious.
  assign accept_data = (state_q == IFU_REQ) && iram_rd_valid_i;
  assign retire      = (state_q == IFU_VALID) && inst_ready_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IFU_IDLE:  state_d = IFU_REQ;
      IFU_REQ:   if (iram_rd_valid_i) state_d = IFU_VALID;
      IFU_VALID: if (inst_ready_i) state_d = target_misaligned ? IFU_HALT : IFU_REQ;
      IFU_HALT:  state_d = IFU_HALT;
      default:   state_d = IFU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IFU_IDLE;
      pc_q         <= RESET_PC;
      inst_data_q  <= '0;
      inst_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept_data) begin
        inst_data_q  <= iram_rd_data_i;
        inst_valid_q <= 1'b1;
      end
      if (retire) begin
        inst_valid_q <= 1'b0;
        if (target_misaligned) begin
          misalign_q <= 1'b1;
        end else begin
          pc_q <= target;
        end
      end
    end
  end

  assign iram_rd_en_o   = (state_q == IFU_REQ);
  assign iram_rd_addr_o = pc_q;
  assign inst_valid_o   = inst_valid_q;
  assign inst_data_o    = inst_data_q;
  assign pc_o           = pc_q;
  assign pc_next_o      = pc_q + XLEN'(4);
  assign misalign_o     = misalign_q;

endmodule

// File: tb/tb_ifu.sv
// Directed bench for the fetch unit with a hand-driven instruction memory.
module tb_ifu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_wr_en;
  logic        pc_wr_sel;
  logic [31:0] imm_data;
  logic [31:0] alu_data;
  logic        inst_ready;
  logic        iram_rd_en;
  logic [31:0] iram_rd_addr;
  logic        iram_rd_valid;
  logic [31:0] iram_rd_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        misalign;

  int checks   = 0;
  int failures = 0;

  ifu #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .pc_wr_en_i      (pc_wr_en),
    .pc_wr_sel_i     (pc_wr_sel),
    .imm_data_i      (imm_data),
    .alu_data_i      (alu_data),
    .inst_ready_i    (inst_ready),
    .iram_rd_en_o    (iram_rd_en),
    .iram_rd_addr_o  (iram_rd_addr),
    .iram_rd_valid_i (iram_rd_valid),
    .iram_rd_data_i  (iram_rd_data),
    .inst_valid_o    (inst_valid),
    .inst_data_o     (inst_data),
    .pc_o            (pc),
    .pc_next_o       (pc_next),
    .misalign_o      (misalign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory answers after wait_cycles extra cycles; address must stay put meanwhile.
  task automatic mem_respond(input int wait_cycles, input logic [31:0] data, input logic [31:0] addr);
    for (int i = 0; i < wait_cycles; i++) begin
      chk("req_en_wait", {31'b0, iram_rd_en}, 32'd1);
      chk("req_addr_wait", iram_rd_addr, addr);
      tick();
    end
    chk("req_en", {31'b0, iram_rd_en}, 32'd1);
    chk("req_addr", iram_rd_addr, addr);
    iram_rd_valid = 1'b1;
    iram_rd_data  = data;
    tick();
    iram_rd_valid = 1'b0;
    iram_rd_data  = 32'h0;
    chk("held_valid", {31'b0, inst_valid}, 32'd1);
    chk("held_data", inst_data, data);
    chk("held_pc", pc, addr);
    chk("held_no_req", {31'b0, iram_rd_en}, 32'd0);
  endtask

  task automatic retire(input logic en, input logic sel, input logic [31:0] imm, input logic [31:0] alu);
    pc_wr_en   = en;
    pc_wr_sel  = sel;
    imm_data   = imm;
    alu_data   = alu;
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    pc_wr_en   = 1'b0;
    pc_wr_sel  = 1'b0;
    imm_data   = 32'h0;
    alu_data   = 32'h0;
  endtask

  initial begin
    rst_n         = 1'b0;
    pc_wr_en      = 1'b0;
    pc_wr_sel     = 1'b0;
    imm_data      = 32'h0;
    alu_data      = 32'h0;
    inst_ready    = 1'b0;
    iram_rd_valid = 1'b0;
    iram_rd_data  = 32'h0;
    tick();
    tick();

    // Reset values
    chk("rst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_en", {31'b0, iram_rd_en}, 32'd0);
    chk("rst_misalign", {31'b0, misalign}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc_next", pc_next, 32'h4);
    chk("rst_data", inst_data, 32'h0);

    // Release: cycle 0 IDLE, cycle 1 REQ, 1-cycle memory, valid in cycle 3
    rst_n = 1'b1;
    chk("idle_no_req", {31'b0, iram_rd_en}, 32'd0);
    tick();
    mem_respond(1, 32'h0000_0013, 32'h0);

    // Jump to 0x100, then sequential retire
    retire(1'b1, 1'b0, 32'h0000_0100, 32'h0);
    chk("rel_addr", iram_rd_addr, 32'h100);
    chk("rel_valid_drop", {31'b0, inst_valid}, 32'd0);
    mem_respond(1, 32'h0000_0093, 32'h100);
    chk("pc_next_100", pc_next, 32'h104);
    retire(1'b0, 1'b1, 32'h1234_5678, 32'h0000_0777);
    chk("seq_addr", iram_rd_addr, 32'h104);

    // Negative immediate from 0x100
    mem_respond(0, 32'h0000_0113, 32'h104);
    retire(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0);
    mem_respond(0, 32'h0000_0193, 32'h100);
    retire(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0);
    chk("imm_neg_addr", iram_rd_addr, 32'h0F8);

    // JALR from 0x100 with bit0 set in the ALU result
    mem_respond(0, 32'h0000_0213, 32'h0F8);
    retire(1'b1, 1'b0, 32'h0000_0008, 32'h0);
    mem_respond(0, 32'h0000_0293, 32'h100);
    retire(1'b1, 1'b1, 32'h0000_0040, 32'h0000_2001);
    chk("jalr_addr", iram_rd_addr, 32'h2000);

    // 3-cycle memory wait, then a spurious valid pulse while holding
    mem_respond(3, 32'hCAFE_0013, 32'h2000);
    iram_rd_valid = 1'b1;
    iram_rd_data  = 32'hDEAD_BEEF;
    tick();
    iram_rd_valid = 1'b0;
    iram_rd_data  = 32'h0;
    chk("spurious_data", inst_data, 32'hCAFE_0013);
    chk("spurious_valid", {31'b0, inst_valid}, 32'd1);
    chk("spurious_no_req", {31'b0, iram_rd_en}, 32'd0);

    // Top-of-memory wrap: 0xFFFFFFFC + 4 = 0
    retire(1'b1, 1'b1, 32'h0, 32'hFFFF_FFFC);
    mem_respond(0, 32'h0000_0313, 32'hFFFF_FFFC);
    chk("wrap_pc_next", pc_next, 32'h0);
    retire(1'b0, 1'b0, 32'h0, 32'h0);
    chk("wrap_addr", iram_rd_addr, 32'h0);
    mem_respond(0, 32'h0000_0393, 32'h0);

    // Misaligned JALR target halts the fetch
    retire(1'b1, 1'b1, 32'h0, 32'h0000_2002);
    chk("mis_set", {31'b0, misalign}, 32'd1);
    chk("mis_pc_kept", pc, 32'h0);
    chk("mis_valid_drop", {31'b0, inst_valid}, 32'd0);
    chk("mis_no_req", {31'b0, iram_rd_en}, 32'd0);
    iram_rd_valid = 1'b1;
    inst_ready    = 1'b1;
    pc_wr_en      = 1'b1;
    imm_data      = 32'h0000_0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("halt_no_req", {31'b0, iram_rd_en}, 32'd0);
    end
    iram_rd_valid = 1'b0;
    inst_ready    = 1'b0;
    pc_wr_en      = 1'b0;
    imm_data      = 32'h0;
    chk("halt_mis_sticky", {31'b0, misalign}, 32'd1);
    chk("halt_pc", pc, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("rst_clears_mis", {31'b0, misalign}, 32'd0);
    tick();

    // Reset mid-request with late memory data after release
    rst_n = 1'b1;
    tick();
    chk("req2_en", {31'b0, iram_rd_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("req_drop_async", {31'b0, iram_rd_en}, 32'd0);
    tick();
    rst_n         = 1'b1;
    iram_rd_valid = 1'b1;
    iram_rd_data  = 32'h0000_0BAD;
    tick();
    iram_rd_valid = 1'b0;
    iram_rd_data  = 32'h0;
    chk("late_valid", {31'b0, inst_valid}, 32'd0);
    chk("late_data", inst_data, 32'h0);
    mem_respond(1, 32'h0000_0013, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
